// File: rtl/midi_pkg.sv
// Shared types and byte constants for the MIDI channel-message parser.
package midi_pkg;

    typedef enum logic [2:0] {
        NOTE_OFF   = 3'd0,
        NOTE_ON    = 3'd1,
        POLY_AT    = 3'd2,
        CC         = 3'd3,
        PROGRAM    = 3'd4,
        CHAN_AT    = 3'd5,
        PITCH_BEND = 3'd6
    } msg_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA1 = 2'd1,
        DATA2 = 2'd2,
        SYSEX = 2'd3
    } state_e;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

endpackage

// File: rtl/midi_status_decode.sv
// Combinational classification of a MIDI status byte.
module midi_status_decode
    import midi_pkg::*;
(
    input  logic [7:0] status,
    output msg_type_e  msg_type,
    output logic [1:0] length,
    output logic       is_channel,
    output logic       is_realtime
);

    always_comb begin
        is_channel  = status[7] && (status < SYSEX_START);
        is_realtime = (status >= RT_MIN);
        msg_type    = is_channel ? msg_type_e'(status[6:4]) : NOTE_OFF;
        length      = (msg_type == PROGRAM || msg_type == CHAN_AT) ? 2'd1 : 2'd2;
    end

endmodule

// File: rtl/midi_msg_parser.sv
// Byte-stream MIDI parser: running status, sysex skipping, realtime pass-through.
// Handshake: a byte is consumed in any cycle with d_valid=1 (no ready, no stall);
// v_valid and rt_valid are single-cycle strobes with no acknowledge.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
    parameter bit          VEL0_IS_OFF  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  d_in,
    input  logic        d_valid,
    input  logic        f_error,
    output logic        v_valid,
    output msg_type_e   v_type,
    output logic [3:0]  v_channel,
    output logic [6:0]  v_data1,
    output logic [6:0]  v_data2,
    output logic [13:0] v_bend,
    output logic        rt_valid,
    output logic [7:0]  rt_byte,
    output state_e      dbg_state
);

    state_e     state;
    msg_type_e  rs_type;
    logic [3:0] rs_chan;
    logic [1:0] rs_len;
    logic [6:0] d1_q;

    msg_type_e  dec_type;
    logic [1:0] dec_len;
    logic       dec_chan;
    logic       dec_rt;

    logic       is_data;
    logic       complete;
    logic       emit;
    logic [6:0] c_d1;
    logic [6:0] c_d2;
    msg_type_e  c_type;

    midi_status_decode u_dec (
        .status      (d_in),
        .msg_type    (dec_type),
        .length      (dec_len),
        .is_channel  (dec_chan),
        .is_realtime (dec_rt)
    );

    assign dbg_state = state;

    // Completion is decided combinationally so the result registers on the final byte's edge.
    always_comb begin
        is_data  = d_valid && !f_error && !d_in[7];
        complete = 1'b0;
        c_d1     = d1_q;
        c_d2     = 7'd0;
        if (is_data && state == DATA1 && rs_len == 2'd1) begin
            complete = 1'b1;
            c_d1     = d_in[6:0];
        end else if (is_data && state == DATA2) begin
            complete = 1'b1;
            c_d2     = d_in[6:0];
        end
        c_type = rs_type;
        if (VEL0_IS_OFF && rs_type == NOTE_ON && c_d2 == 7'd0) begin
            c_type = NOTE_OFF;
        end
        emit = complete && CHANNEL_MASK[rs_chan];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rs_type   <= NOTE_OFF;
            rs_chan   <= 4'd0;
            rs_len    <= 2'd0;
            d1_q      <= 7'd0;
            v_valid   <= 1'b0;
            v_type    <= NOTE_OFF;
            v_channel <= 4'd0;
            v_data1   <= 7'd0;
            v_data2   <= 7'd0;
            v_bend    <= 14'd0;
            rt_valid  <= 1'b0;
            rt_byte   <= 8'd0;
        end else begin
            v_valid  <= emit;
            rt_valid <= 1'b0;
            if (emit) begin
                v_type    <= c_type;
                v_channel <= rs_chan;
                v_data1   <= c_d1;
                v_data2   <= c_d2;
                v_bend    <= (rs_type == PITCH_BEND) ? {c_d2, c_d1} : 14'd0;
            end
            if (d_valid) begin
                if (f_error) begin
                    state <= IDLE;
                end else if (dec_rt) begin
                    rt_valid <= 1'b1;
                    rt_byte  <= d_in;
                end else if (dec_chan) begin
                    rs_type <= dec_type;
                    rs_chan <= d_in[3:0];
                    rs_len  <= dec_len;
                    state   <= DATA1;
                end else if (d_in == SYSEX_START) begin
                    state <= SYSEX;
                end else if (d_in > SYSEX_START && d_in <= SYSEX_END) begin
                    state <= IDLE;
                end else begin
                    case (state)
                        DATA1: begin
                            if (rs_len == 2'd2) begin
                                d1_q  <= d_in[6:0];
                                state <= DATA2;
                            end
                        end
                        DATA2:   state <= DATA1;
                        default: state <= state;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: default instance plus a masked, VEL0_IS_OFF=0 instance.
module tb_midi_msg_parser;
    import midi_pkg::*;

    localparam logic [15:0] B_MASK = 16'h0001;

    typedef struct packed {
        logic        v_valid;
        logic [2:0]  v_type;
        logic [3:0]  v_channel;
        logic [6:0]  v_data1;
        logic [6:0]  v_data2;
        logic [13:0] v_bend;
        logic        rt_valid;
    } out_t;

    typedef struct packed {
        logic [7:0] b;
        logic       fe;
        out_t       e;
        logic [7:0] erb;
    } vec_t;

    logic clk, reset, d_valid, f_error;
    logic [7:0] d_in;

    logic a_v_valid, a_rt_valid, b_v_valid, b_rt_valid;
    msg_type_e a_v_type, b_v_type;
    logic [3:0] a_v_channel, b_v_channel;
    logic [6:0] a_v_data1, a_v_data2, b_v_data1, b_v_data2;
    logic [13:0] a_v_bend, b_v_bend;
    logic [7:0] a_rt_byte, b_rt_byte;
    state_e a_state, b_state;

    int total = 0;
    int bad = 0;

    out_t       m_out [2];
    logic [7:0] m_rtb [2];
    logic [7:0] m_rs  [2];
    int         m_n   [2];
    logic [6:0] m_buf [2][2];
    vec_t       vt[$];

    midi_msg_parser dut_a (
        .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .f_error(f_error),
        .v_valid(a_v_valid), .v_type(a_v_type), .v_channel(a_v_channel),
        .v_data1(a_v_data1), .v_data2(a_v_data2), .v_bend(a_v_bend),
        .rt_valid(a_rt_valid), .rt_byte(a_rt_byte), .dbg_state(a_state)
    );

    midi_msg_parser #(.CHANNEL_MASK(B_MASK), .VEL0_IS_OFF(1'b0)) dut_b (
        .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .f_error(f_error),
        .v_valid(b_v_valid), .v_type(b_v_type), .v_channel(b_v_channel),
        .v_data1(b_v_data1), .v_data2(b_v_data2), .v_bend(b_v_bend),
        .rt_valid(b_rt_valid), .rt_byte(b_rt_byte), .dbg_state(b_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic out_t pack_a();
        return {a_v_valid, a_v_type, a_v_channel, a_v_data1, a_v_data2, a_v_bend, a_rt_valid};
    endfunction

    function automatic out_t pack_b();
        return {b_v_valid, b_v_type, b_v_channel, b_v_data1, b_v_data2, b_v_bend, b_rt_valid};
    endfunction

    function automatic out_t o(input logic v, input logic [2:0] t, input logic [3:0] ch,
                               input logic [6:0] d1, input logic [6:0] d2,
                               input logic [13:0] bend, input logic rv);
        return {v, t, ch, d1, d2, bend, rv};
    endfunction

    task automatic add(input logic [7:0] b, input logic fe, input out_t e, input logic [7:0] erb);
        vec_t v;
        v.b = b; v.fe = fe; v.e = e; v.erb = erb;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: collect data bytes under the current running status until the
    // message length for that status nibble is reached.
    task automatic model(input int i, input logic rst, input logic dv,
                         input logic [7:0] b, input logic fe);
        out_t o_n;
        int need;
        logic [15:0] mask;
        logic vel0;
        logic [6:0] d1, d2;
        logic [2:0] t;
        mask = (i == 0) ? 16'hFFFF : B_MASK;
        vel0 = (i == 0);
        o_n = m_out[i];
        o_n.v_valid = 1'b0;
        o_n.rt_valid = 1'b0;
        if (rst) begin
            o_n = '0; m_rtb[i] = 8'h00; m_rs[i] = 8'h00; m_n[i] = 0;
        end else if (dv) begin
            if (fe) begin
                m_rs[i] = 8'h00; m_n[i] = 0;
            end else if (b >= 8'hF8) begin
                o_n.rt_valid = 1'b1; m_rtb[i] = b;
            end else if (b >= 8'hF0) begin
                m_rs[i] = 8'h00; m_n[i] = 0;
            end else if (b >= 8'h80) begin
                m_rs[i] = b; m_n[i] = 0;
            end else if (m_rs[i] != 8'h00) begin
                m_buf[i][m_n[i]] = b[6:0];
                m_n[i]++;
                need = (m_rs[i][7:4] == 4'hC || m_rs[i][7:4] == 4'hD) ? 1 : 2;
                if (m_n[i] == need) begin
                    m_n[i] = 0;
                    if (mask[m_rs[i][3:0]]) begin
                        t  = 3'(m_rs[i][7:4] - 4'h8);
                        d1 = m_buf[i][0];
                        d2 = (need == 2) ? m_buf[i][1] : 7'd0;
                        if (vel0 && t == 3'd1 && d2 == 7'd0) t = 3'd0;
                        o_n.v_valid   = 1'b1;
                        o_n.v_type    = t;
                        o_n.v_channel = m_rs[i][3:0];
                        o_n.v_data1   = d1;
                        o_n.v_data2   = d2;
                        o_n.v_bend    = (t == 3'd6) ? {d2, d1} : 14'd0;
                    end
                end
            end
        end
        m_out[i] = o_n;
    endtask

    task automatic step(input logic rst, input logic dv, input logic [7:0] b, input logic fe);
        @(negedge clk);
        reset = rst; d_valid = dv; d_in = b; f_error = fe;
        @(posedge clk);
        #1;
        model(0, rst, dv, b, fe);
        model(1, rst, dv, b, fe);
        chk("model_a", 64'(pack_a()), 64'(m_out[0]));
        chk("model_b", 64'(pack_b()), 64'(m_out[1]));
        if (m_out[0].rt_valid) chk("model_a_rtbyte", 64'(a_rt_byte), 64'(m_rtb[0]));
        if (m_out[1].rt_valid) chk("model_b_rtbyte", 64'(b_rt_byte), 64'(m_rtb[1]));
        reset = 1'b0; d_valid = 1'b0; f_error = 1'b0;
    endtask

    task automatic send3(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        step(1'b0, 1'b1, x, 1'b0);
        step(1'b0, 1'b1, y, 1'b0);
        step(1'b0, 1'b1, z, 1'b0);
    endtask

    initial begin
        out_t h, h2, rt;
        int r;
        logic [7:0] b;
        reset = 1'b1; d_valid = 1'b0; f_error = 1'b0; d_in = 8'h00;

        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h90, 1'b0);
        chk("reset_state_a", 64'(a_state), 64'(IDLE));
        chk("reset_out_a", 64'(pack_a()), 64'd0);

        h  = o(0, 3'd6, 4'd0, 7'h00, 7'h40, 14'h2000, 0);
        h2 = o(0, 3'd1, 4'd0, 7'h3C, 7'h40, 14'h0, 0);
        rt = o(0, 3'd6, 4'd0, 7'h00, 7'h40, 14'h2000, 1);
        add(8'h91, 0, o(0, 0, 0, 0, 0, 0, 0), 0);
        add(8'h3C, 0, o(0, 0, 0, 0, 0, 0, 0), 0);
        add(8'h64, 0, o(1, 3'd1, 4'd1, 7'h3C, 7'h64, 0, 0), 0);
        add(8'h3E, 0, o(0, 3'd1, 4'd1, 7'h3C, 7'h64, 0, 0), 0);
        add(8'h00, 0, o(1, 3'd0, 4'd1, 7'h3E, 7'h00, 0, 0), 0);
        add(8'hC5, 0, o(0, 3'd0, 4'd1, 7'h3E, 7'h00, 0, 0), 0);
        add(8'h07, 0, o(1, 3'd4, 4'd5, 7'h07, 7'h00, 0, 0), 0);
        add(8'hE0, 0, o(0, 3'd4, 4'd5, 7'h07, 7'h00, 0, 0), 0);
        add(8'h00, 0, o(0, 3'd4, 4'd5, 7'h07, 7'h00, 0, 0), 0);
        add(8'h40, 0, o(1, 3'd6, 4'd0, 7'h00, 7'h40, 14'h2000, 0), 0);
        add(8'h90, 0, h, 0);
        add(8'hF8, 0, rt, 8'hF8);
        add(8'h3C, 0, h, 0);
        add(8'hFE, 0, rt, 8'hFE);
        add(8'h40, 0, o(1, 3'd1, 4'd0, 7'h3C, 7'h40, 0, 0), 0);
        add(8'hF0, 0, h2, 0);
        add(8'h7E, 0, h2, 0);
        add(8'h01, 0, h2, 0);
        add(8'hF7, 0, h2, 0);
        add(8'h3C, 0, h2, 0);
        add(8'h40, 0, h2, 0);
        add(8'h92, 0, h2, 0);
        add(8'h3C, 0, h2, 0);
        add(8'h40, 1, h2, 0);
        add(8'h40, 0, h2, 0);

        foreach (vt[k]) begin
            step(1'b0, 1'b1, vt[k].b, vt[k].fe);
            chk($sformatf("vec%0d", k), 64'(pack_a()), 64'(vt[k].e));
            if (vt[k].e.rt_valid) chk($sformatf("vec%0d_rtbyte", k), 64'(a_rt_byte), 64'(vt[k].erb));
        end

        // Running-status note-off, with and without velocity-0 folding.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send3(8'h90, 8'h3C, 8'h64);
        step(1'b0, 1'b1, 8'h3E, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("vel0_off_a", 64'(pack_a()), 64'(o(1, 3'd0, 4'd0, 7'h3E, 7'h00, 0, 0)));
        chk("vel0_on_b", 64'(pack_b()), 64'(o(1, 3'd1, 4'd0, 7'h3E, 7'h00, 0, 0)));

        // Channel 2 masked in instance b.
        send3(8'h92, 8'h3C, 8'h40);
        chk("mask_a", 64'(pack_a()), 64'(o(1, 3'd2 - 3'd1, 4'd2, 7'h3C, 7'h40, 0, 0)));
        chk("mask_b", 64'(pack_b()), 64'(o(0, 3'd1, 4'd0, 7'h3E, 7'h00, 0, 0)));
        send3(8'h90, 8'h3C, 8'h40);
        chk("unmask_b", 64'(pack_b()), 64'(o(1, 3'd1, 4'd0, 7'h3C, 7'h40, 0, 0)));

        // Reset mid-message drops the partial note.
        step(1'b0, 1'b1, 8'h90, 1'b0);
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        step(1'b1, 1'b1, 8'h40, 1'b0);
        step(1'b0, 1'b1, 8'h40, 1'b0);
        chk("rst_mid_a", 64'(pack_a()), 64'd0);
        chk("rst_mid_b", 64'(pack_b()), 64'd0);

        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      b = {1'b0, 7'($urandom_range(0, 127))};
            else if (r < 80) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 90) b = 8'($urandom_range(8'hF8, 8'hFF));
            else             b = 8'($urandom_range(8'hF0, 8'hF7));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), b,
                 ($urandom_range(0, 39) == 0));
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
